// File: rtl/mux421_rr_arbiter_if.sv
// mux421_rr_arbiter_if: request/grant/select bundle between requesters and the 4:1 mux arbiter
interface mux421_rr_arbiter_if;
  logic [3:0] req;
  logic done;
  logic [3:0] gnt;
  logic sel1;
  logic sel0;
  logic busy;
  logic timeout;
  modport master (output req, done, input gnt, sel1, sel0, busy, timeout);
  modport slave (input req, done, output gnt, sel1, sel0, busy, timeout);
endinterface

// File: rtl/mux421_rr_arbiter.sv
// mux421_rr_arbiter: round-robin 4:1 mux arbiter with hold limit and one-cycle break-before-make gap
module mux421_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input logic i_clk,
  input logic i_rst,
  mux421_rr_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  state_t r_state;
  logic [1:0] r_p, r_sel, w_idx;
  logic [3:0] r_hc, r_gnt;
  logic r_busy, r_timeout, w_drop, w_max, w_rel;
  // descending scan so the requester nearest the pointer wins
  always_comb begin
    w_idx = r_p;
    for (int k = 3; k >= 0; k--) w_idx = bus.req[r_p + 2'(k)] ? r_p + 2'(k) : w_idx;
  end
  assign w_drop = ~bus.req[r_sel];
  assign w_max = r_hc == 4'(MAX_HOLD);
  assign w_rel = bus.done | w_drop | w_max;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_p <= '0;
      r_hc <= '0;
      r_gnt <= '0;
      r_sel <= '0;
      r_busy <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: if (|bus.req) begin
          r_state <= GRANT;
          r_gnt <= 4'b1 << w_idx;
          r_sel <= w_idx;
          r_p <= w_idx + 2'd1;
          r_hc <= 4'd1;
          r_busy <= 1'b1;
        end
        GRANT: if (w_rel) begin
          r_state <= GAP;
          r_gnt <= '0;
          r_busy <= 1'b0;
          r_timeout <= w_max & ~bus.done & ~w_drop;
        end else r_hc <= r_hc + 4'd1;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.gnt = r_gnt;
  assign bus.sel1 = r_sel[1];
  assign bus.sel0 = r_sel[0];
  assign bus.busy = r_busy;
  assign bus.timeout = r_timeout;
endmodule

// File: tb/tb_mux421_rr_arbiter.sv
// tb_mux421_rr_arbiter: directed scenarios plus random traffic against a behavioural arbiter model
module tb_mux421_rr_arbiter;
  localparam int MH = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int m_state = 0, m_p = 0, m_hc = 0, m_own = 0, m_sel = 0;
  bit m_to = 1'b0;
  mux421_rr_arbiter_if bus();
  mux421_rr_arbiter #(.MAX_HOLD(MH)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // model state: 0 idle, 1 owner holds grant, 2 gap
  task automatic model(logic [3:0] req, logic done, logic r);
    if (r) begin
      m_state = 0; m_p = 0; m_hc = 0; m_sel = 0; m_to = 1'b0;
      return;
    end
    m_to = 1'b0;
    if (m_state == 0) begin
      if (req != 4'd0) begin
        for (int k = 0; k < 4; k++) if (req[(m_p + k) % 4]) begin m_own = (m_p + k) % 4; break; end
        m_sel = m_own; m_p = (m_own + 1) % 4; m_hc = 1; m_state = 1;
      end
    end else if (m_state == 1) begin
      if (done || !req[m_own] || m_hc == MH) begin
        m_to = !done && req[m_own] && m_hc == MH;
        m_state = 2;
      end else m_hc++;
    end else m_state = 0;
  endtask

  task automatic cyc(logic [3:0] req, logic done, logic r);
    bus.req = req;
    bus.done = done;
    rst = r;
    @(posedge clk);
    model(req, done, r);
    #1;
    chk("gnt", {4'd0, bus.gnt}, m_state == 1 ? 8'(1 << m_own) : 8'd0);
    chk("sel", {6'd0, bus.sel1, bus.sel0}, 8'(m_sel));
    chk("busy", {7'd0, bus.busy}, 8'(m_state == 1));
    chk("timeout", {7'd0, bus.timeout}, 8'(m_to));
    chk("onehot", 8'($countones(bus.gnt) <= 1), 8'd1);
  endtask

  initial begin
    logic [3:0] prev;
    logic [3:0] seq[$];
    logic [3:0] want[5];
    logic [3:0] rq;
    want = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.req = '0;
    bus.done = 1'b0;
    cyc(4'd0, 1'b0, 1'b1);
    cyc(4'd0, 1'b0, 1'b1);
    chk("rst_gnt", {4'd0, bus.gnt}, 8'd0);
    chk("rst_busy", {7'd0, bus.busy}, 8'd0);
    // single requester
    cyc(4'b0001, 1'b0, 1'b0);
    chk("r29_gnt", {4'd0, bus.gnt}, 8'd1);
    chk("r29_sel", {6'd0, bus.sel1, bus.sel0}, 8'd0);
    chk("r29_busy", {7'd0, bus.busy}, 8'd1);
    // all request, done every second grant cycle
    cyc(4'd0, 1'b0, 1'b1);
    prev = '0;
    for (int c = 0; c < 22; c++) begin
      cyc(4'hF, m_state == 1 && m_hc == 2, 1'b0);
      if (bus.gnt != 4'd0 && prev == 4'd0) seq.push_back(bus.gnt);
      prev = bus.gnt;
    end
    chk("r30_count", 8'(seq.size() >= 5), 8'd1);
    for (int g = 0; g < 5 && g < seq.size(); g++) chk("r30_order", {4'd0, seq[g]}, {4'd0, want[g]});
    // hold limit forces release
    cyc(4'd0, 1'b0, 1'b1);
    cyc(4'b0100, 1'b0, 1'b0);
    for (int c = 0; c < 7; c++) begin
      cyc(4'b0100, 1'b0, 1'b0);
      chk("r31_hold", {4'd0, bus.gnt}, 8'h04);
    end
    cyc(4'b0100, 1'b0, 1'b0);
    chk("r31_gap_gnt", {4'd0, bus.gnt}, 8'd0);
    chk("r31_to", {7'd0, bus.timeout}, 8'd1);
    cyc(4'b0100, 1'b0, 1'b0);
    chk("r31_idle_to", {7'd0, bus.timeout}, 8'd0);
    cyc(4'b0100, 1'b0, 1'b0);
    chk("r31_regrant", {4'd0, bus.gnt}, 8'h04);
    // done coinciding with hold limit suppresses timeout
    for (int c = 0; c < 7; c++) cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b0100, 1'b1, 1'b0);
    chk("r32_gnt", {4'd0, bus.gnt}, 8'd0);
    chk("r32_to", {7'd0, bus.timeout}, 8'd0);
    // reset mid-grant
    cyc(4'd0, 1'b0, 1'b1);
    cyc(4'b1000, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    chk("r33_sel_pre", {6'd0, bus.sel1, bus.sel0}, 8'd3);
    cyc(4'b1000, 1'b0, 1'b1);
    chk("r33_gnt", {4'd0, bus.gnt}, 8'd0);
    chk("r33_sel", {6'd0, bus.sel1, bus.sel0}, 8'd0);
    chk("r33_busy", {7'd0, bus.busy}, 8'd0);
    cyc(4'b1010, 1'b0, 1'b0);
    chk("r33_first", {4'd0, bus.gnt}, 8'h02);
    // owner drops request, other requester next
    cyc(4'b1010, 1'b0, 1'b0);
    cyc(4'b1000, 1'b0, 1'b0);
    chk("r34_gap_sel", {6'd0, bus.sel1, bus.sel0}, 8'd1);
    cyc(4'b1000, 1'b0, 1'b0);
    chk("r34_idle_sel", {6'd0, bus.sel1, bus.sel0}, 8'd1);
    cyc(4'b1000, 1'b0, 1'b0);
    chk("r34_gnt", {4'd0, bus.gnt}, 8'h08);
    chk("r34_sel", {6'd0, bus.sel1, bus.sel0}, 8'd3);
    // random traffic with mostly-stable requests
    rq = 4'hF;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) rq = 4'($urandom_range(0, 15));
      cyc(rq, $urandom_range(0, 11) == 0, $urandom_range(0, 79) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
